// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU bus / DMA bus-mux signal bundle for the OAM DMA sequencer
interface oam_dma_ctrl_if;
    logic        cpu_ce;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic        odd_or_even;
    logic [7:0]  rd_data;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        dma_wr;
    logic [7:0]  dma_dout;
    logic        busy;
    logic        done;

    modport master (
        output cpu_ce, bus_addr, bus_din, bus_wr, odd_or_even, rd_data,
        input  dma_hijack, dma_addr, dma_wr, dma_dout, busy, done
    );

    modport slave (
        input  cpu_ce, bus_addr, bus_din, bus_wr, odd_or_even, rd_data,
        output dma_hijack, dma_addr, dma_wr, dma_dout, busy, done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA sequencer copying one CPU page into OAM via the OAM data port
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic             ppu_clk,
    input  logic             reset,
    oam_dma_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic        hijack_q, hijack_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  dout_q, dout_d;
    logic        done_q, done_d;

    always_ff @(posedge ppu_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            latch_q  <= 8'h00;
            hijack_q <= 1'b0;
            addr_q   <= 16'h0000;
            wr_q     <= 1'b0;
            dout_q   <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            hijack_q <= hijack_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        done_d  = 1'b0;

        if (bus.cpu_ce) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.bus_wr && (bus.bus_addr == DMA_REG_ADDR)) begin
                        page_d  = bus.bus_din;
                        idx_d   = 8'h00;
                        state_d = S_HALT;
                    end
                end
                S_HALT:  state_d = bus.odd_or_even ? S_ALIGN : S_READ;
                S_ALIGN: state_d = S_READ;
                S_READ: begin
                    latch_d = bus.rd_data;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    // End on idx FF rather than on wrap so page never advances.
                    if (idx_q == 8'hFF) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from next state and registered, keeping bus_* off the output path.
        hijack_d = (state_d != S_IDLE);
        wr_d     = (state_d == S_WRITE);
        addr_d   = 16'h0000;
        dout_d   = 8'h00;
        case (state_d)
            S_READ:  addr_d = {page_d, idx_d};
            S_WRITE: begin
                addr_d = OAM_DATA_ADDR;
                dout_d = latch_d;
            end
            default: ;
        endcase
    end

    assign bus.dma_hijack = hijack_q;
    assign bus.busy       = hijack_q;
    assign bus.dma_addr   = addr_q;
    assign bus.dma_wr     = wr_q;
    assign bus.dma_dout   = dout_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

    logic ppu_clk = 1'b0;
    logic reset;

    always #5 ppu_clk = ~ppu_clk;

    oam_dma_ctrl_if dif ();

    // RAM model: each byte of a page reads back as its low address bits xor A5.
    assign dif.rd_data = dif.dma_addr[7:0] ^ 8'hA5;

    oam_dma_ctrl dut (
        .ppu_clk (ppu_clk),
        .reset   (reset),
        .bus     (dif)
    );

    typedef struct packed {
        logic [15:0] rd_addr;
        logic [7:0]  data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec    = 0;
    int          n_bad    = 0;
    int          hij_cnt  = 0;
    int          done_cnt = 0;
    int          wr_cnt   = 0;
    logic [15:0] last_addr = 16'h0000;
    logic        prev_valid = 1'b0;
    logic        prev_ce    = 1'b0;
    logic        prev_rst   = 1'b1;
    logic [25:0] prev_out   = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge ppu_clk);
        #2;
    endtask

    task automatic cpu_cyc(input int gap);
        repeat (gap) tick();
        dif.cpu_ce = 1'b1;
        tick();
        dif.cpu_ce = 1'b0;
    endtask

    task automatic clear_bus();
        dif.bus_addr = 16'h0000;
        dif.bus_wr   = 1'b0;
        dif.bus_din  = 8'h00;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each consumed DMA write.
    initial begin
        forever begin
            @(negedge ppu_clk);
            if (prev_valid && !prev_ce && !prev_rst)
                chk("hold_in_gap", {dif.dma_hijack, dif.dma_addr, dif.dma_wr, dif.dma_dout}, prev_out);
            if (dif.done) done_cnt++;
            if (dif.cpu_ce && !reset) begin
                chk("busy_eq_hijack", dif.busy, dif.dma_hijack);
                if (dif.dma_hijack) hij_cnt++;
                if (dif.dma_wr) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("read_addr", last_addr, mon_e.rd_addr);
                        chk("write_addr", dif.dma_addr, 16'h2004);
                        chk("write_data", dif.dma_dout, mon_e.data);
                    end
                    wr_cnt++;
                end
                last_addr = dif.dma_addr;
            end
            prev_valid = 1'b1;
            prev_ce    = dif.cpu_ce;
            prev_rst   = reset;
            prev_out   = {dif.dma_hijack, dif.dma_addr, dif.dma_wr, dif.dma_dout};
        end
    end

    task automatic xfer(input logic [7:0] pg, input logic odd, input int max_gap,
                        input int retrig_at, input int reset_at, input int exp_cyc);
        int  n;
        int  gap;
        bit  retrig_done;
        retrig_done = 0;
        hij_cnt  = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.rd_addr = {pg, 8'(i)};
            e.data    = 8'(i) ^ 8'hA5;
            sb.push_back(e);
        end
        dif.odd_or_even = odd;
        dif.bus_addr = 16'h4014;
        dif.bus_wr   = 1'b1;
        dif.bus_din  = pg;
        cpu_cyc(0);
        clear_bus();
        chk("hijack_after_trigger", dif.dma_hijack, 1);
        n = odd ? 2 : 1;
        repeat (n) cpu_cyc(max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
        chk("first_read_addr", dif.dma_addr, {pg, 8'h00});
        chk("first_read_wr", dif.dma_wr, 0);
        while (dif.dma_hijack && n < 1200) begin
            if (reset_at >= 0 && wr_cnt == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("reset_hijack", dif.dma_hijack, 0);
                chk("reset_wr", dif.dma_wr, 0);
                chk("reset_done", dif.done, 0);
                sb.delete();
                repeat (3) tick();
                chk("reset_no_done", done_cnt, 0);
                return;
            end
            if (retrig_at >= 0 && !retrig_done && wr_cnt == retrig_at) begin
                dif.bus_addr = 16'h4014;
                dif.bus_wr   = 1'b1;
                dif.bus_din  = 8'h07;
                retrig_done  = 1;
            end
            gap = max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0;
            cpu_cyc(gap);
            clear_bus();
            n++;
        end
        if (n >= 1200) chk("transfer_timeout", 1, 0);
        chk("done_pulse", dif.done, 1);
        tick();
        chk("done_one_clock", dif.done, 0);
        tick();
        chk("done_count", done_cnt, 1);
        chk("hijack_cycles", hij_cnt, exp_cyc);
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_addr", dif.dma_addr, 16'h0000);
        chk("idle_wr", dif.dma_wr, 0);
    endtask

    initial begin
        reset           = 1'b1;
        dif.cpu_ce      = 1'b0;
        dif.odd_or_even = 1'b0;
        clear_bus();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_hijack", dif.dma_hijack, 0);
        chk("rst_busy", dif.busy, 0);
        chk("rst_wr", dif.dma_wr, 0);
        chk("rst_addr", dif.dma_addr, 16'h0000);
        chk("rst_dout", dif.dma_dout, 8'h00);
        chk("rst_done", dif.done, 0);

        dif.bus_addr = 16'h4014;
        dif.bus_din  = 8'h02;
        cpu_cyc(0);
        chk("read_4014_ignored", dif.dma_hijack, 0);
        dif.bus_addr = 16'h4015;
        dif.bus_wr   = 1'b1;
        cpu_cyc(0);
        chk("write_4015_ignored", dif.dma_hijack, 0);
        dif.bus_addr = 16'h4014;
        repeat (4) tick();
        chk("write_no_ce_ignored", dif.dma_hijack, 0);
        clear_bus();
        tick();
        chk("non_trigger_addr", dif.dma_addr, 16'h0000);

        xfer(8'h02, 1'b0, 0, -1, -1, 513);
        xfer(8'h02, 1'b1, 0, -1, -1, 514);
        xfer(8'h02, 1'b0, 7, -1, -1, 513);
        xfer(8'h02, 1'b1, 7, -1, -1, 514);
        xfer(8'h02, 1'b0, 0, 64, -1, 513);
        xfer(8'h02, 1'b0, 0, -1, 128, 0);
        xfer(8'hFF, 1'b0, 3, -1, -1, 513);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sequencer for sprite-memory DMA: a CPU write to the DMA page register stalls the CPU and copies 256 bytes from CPU page `$XX00–$XXFF` into OAM through the OAM data port. It sits between the CPU bus and the PPU register decoder. While active it owns the bus: it drives `dma_hijack` and supplies the address, data and write strobe that the bus mux forwards to the PPU register interface.

## Interface
Parameters:
- `DMA_REG_ADDR`, default `16'h4014`: CPU address of the DMA page register.
- `OAM_DATA_ADDR`, default `16'h2004`: OAM data port address written during transfer.

Ports (clock `ppu_clk`; `reset` is synchronous, active-high):
- `ppu_clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_ce`  in  1  one-`ppu_clk` strobe marking the end of each CPU cycle. All state advances only on `ppu_clk` edges with `cpu_ce`=1.
- `bus_addr`  in  16  CPU bus address.
- `bus_din`  in  8  CPU write data.
- `bus_wr`  in  1  CPU write strobe.
- `odd_or_even`  in  1  CPU cycle parity; 1 means the current CPU cycle is odd.
- `rd_data`  in  8  read data returned for `dma_addr`.
- `dma_hijack`  out  1  bus owned by DMA; the CPU is halted.
- `dma_addr`  out  16  bus address driven during DMA.
- `dma_wr`  out  1  bus write strobe during DMA.
- `dma_dout`  out  8  bus write data during DMA.
- `busy`  out  1  equal to `dma_hijack`.
- `done`  out  1  one-`ppu_clk` pulse on completion.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- **IDLE.** Trigger condition: `cpu_ce`=1 and `bus_wr`=1 and `bus_addr`==`DMA_REG_ADDR`.
  - On trigger, latch `page`<=`bus_din`, clear `idx`<=0, and go to HALT.
  - A read of `DMA_REG_ADDR` (`bus_wr`=0) is ignored.
- **HALT.** One dummy CPU cycle with `dma_wr`=0.
  - On `cpu_ce`: if `odd_or_even`=1, go to ALIGN; otherwise go to READ.
- **ALIGN.** One extra dummy cycle with `dma_wr`=0, then go to READ.
- **READ.**
  - Drives `dma_addr`={`page`,`idx`} with `dma_wr`=0.
  - On `cpu_ce`: `latch`<=`rd_data`, then go to WRITE.
- **WRITE.**
  - Drives `dma_addr`=`OAM_DATA_ADDR`, `dma_wr`=1, `dma_dout`=`latch`.
  - On `cpu_ce`:
    - if `idx`==8'hFF, go to IDLE and pulse `done`;
    - otherwise `idx`<=`idx`+1 (8-bit) and go to READ.
- `idx` is 8 bits. Completion is detected by comparing against `FF`, never by wrap; `page` is never incremented. Page `$FF` is legal and reads `$FF00–$FFFF`.
- Any write to `DMA_REG_ADDR` while busy is ignored: `page` is unchanged and there is no restart.
- The OAM address auto-increments via the `OAM_DATA_ADDR` writes. The block never writes the OAM address register, so the transfer starts at whatever OAM address is current and wraps modulo 256 in OAM.
- Outside IDLE, `dma_hijack`=1. In IDLE: `dma_hijack`=0, `dma_wr`=0, `dma_addr`=0, `dma_dout`=0.

## Timing
- All outputs are registered from state; no combinational path from `bus_*` to the outputs.
- Reset values: state=IDLE, `page`=0, `idx`=0, `latch`=0, `dma_hijack`=0, `busy`=0, `dma_wr`=0, `dma_addr`=0, `dma_dout`=0, `done`=0.
- Reset asserted mid-transfer aborts on the next `ppu_clk` edge. Already-written OAM bytes stay written.
- `dma_hijack` rises on the `ppu_clk` edge that accepts the trigger. It falls on the `cpu_ce` edge that ends the final WRITE; `done` is high for that following `ppu_clk` only.
- Duration in CPU cycles: 1 (HALT) + 512 = 513 when `odd_or_even`=0 at HALT, or 514 with ALIGN.
- `rd_data` must be valid by the `cpu_ce` edge that ends each READ cycle. It is sampled only then.
- With `cpu_ce`=0 all state, counters and outputs hold, including mid-READ and mid-WRITE. `dma_wr` stays high for the whole WRITE CPU cycle; downstream qualifies it with `cpu_ce`.
- A trigger coinciding with reset is dropped.

## Test plan
- **Even start.** Write `8'h02` to `$4014` with `odd_or_even`=0; RAM model returns `addr[7:0]^8'hA5`.
  - Expect 513 `cpu_ce` cycles of hijack.
  - Expect 256 writes to `$2004` with data `i^8'hA5` in order, then one `done` pulse.
- **Odd start.** Same as above but `odd_or_even`=1 at HALT.
  - Expect 514 cycles and an identical data sequence.
  - The first READ address is `$0200`, occurring at the 3rd `cpu_ce` after the trigger.
- **Stall.** Insert random gaps of 0–7 `ppu_clk` between `cpu_ce` pulses.
  - Expect the same byte sequence and the same CPU-cycle count.
  - Expect outputs stable during gaps.
- **Retrigger while busy.** Write `8'h07` to `$4014` at `idx`=`8'h40`.
  - Expect the transfer to continue from page `$02`.
  - Expect no extra cycles and a single `done`.
- **Reset mid-transfer.** Assert reset at `idx`=`8'h80`.
  - Next edge: `dma_hijack`=0, `dma_wr`=0, no `done`.
  - A new trigger with `8'hFF` then completes from `$FF00`.
- **Non-triggers.** Read of `$4014`, write to `$4015`, and write to `$4014` with `cpu_ce`=0.
  - Expect no state change and `dma_hijack` to stay 0.
